// File: rtl/pkt_store_fwd.sv
// Store-and-forward packet buffer: holds each parser frame in RAM until its
// eop is seen, then releases complete frames on a valid/ready byte stream.
// Oversize, truncated and non-fitting frames are discarded and counted.
module pkt_store_fwd #(
  parameter int DEPTH       = 256,
  parameter int MAX_PKT     = 128,
  parameter int LFIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_vld,
  output logic [7:0]  dout,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        dout_vld,
  input  logic        dout_rdy,
  output logic [15:0] drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int LW  = $clog2(MAX_PKT) + 1;
  localparam int FW  = $clog2(LFIFO_DEPTH);
  localparam int FPW = FW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} rd_state_t;

  logic [7:0]     r_mem [DEPTH];
  logic [7:0]     r_ram_q;
  logic [PW-1:0]  r_wr_ptr, r_commit_ptr, r_rd_ptr;
  logic           r_active;
  logic [LW-1:0]  r_len;
  logic [15:0]    r_drop_cnt;
  logic [LW-1:0]  r_lf_mem [LFIFO_DEPTH];
  logic [FPW-1:0] r_lf_wr, r_lf_rd;
  rd_state_t      r_state, w_state_nxt;
  logic [LW-1:0]  r_rem;
  logic [7:0]     r_dout;
  logic           r_sop, r_eop, r_vld;

  logic [FPW-1:0] w_lf_used;
  logic           w_lf_full, w_lf_empty;
  logic [PW-1:0]  w_base, w_used, w_wr_nxt, w_commit_nxt;
  logic [LW-1:0]  w_prev_len, w_frame_len, w_len_nxt;
  logic           w_active_nxt, w_wr_en, w_push, w_drop;
  logic [1:0]     w_drop_inc;
  logic [16:0]    w_drop_sum;
  logic           w_xfer, w_pop;
  logic [AW-1:0]  w_rd_addr;

  assign w_lf_used   = r_lf_wr - r_lf_rd;
  assign w_lf_full   = (w_lf_used == FPW'(LFIFO_DEPTH));
  assign w_lf_empty  = (w_lf_used == '0);
  assign w_frame_len = w_prev_len + 1'b1;
  assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_inc);
  assign w_xfer      = r_vld && dout_rdy;

  // Input-side decision: accept, commit or drop the current byte
  always_comb begin
    w_base       = r_wr_ptr;
    w_prev_len   = r_len;
    w_used       = '0;
    w_wr_nxt     = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_len_nxt    = r_len;
    w_active_nxt = r_active;
    w_wr_en      = 1'b0;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    w_drop_inc   = '0;
    if (din_vld && (din_sop || r_active)) begin
      if (din_sop) begin
        // A new sop always restarts at the commit point; an open frame is lost
        w_base     = r_commit_ptr;
        w_prev_len = '0;
        if (r_active) w_drop_inc = 2'd1;
      end
      w_used = w_base - r_rd_ptr;
      if ((w_prev_len == LW'(MAX_PKT)) || (w_used == PW'(DEPTH)) || (din_eop && w_lf_full)) begin
        w_drop = 1'b1;
      end else begin
        w_wr_en  = 1'b1;
        w_wr_nxt = w_base + 1'b1;
        if (din_eop) begin
          w_push       = 1'b1;
          w_commit_nxt = w_base + 1'b1;
          w_active_nxt = 1'b0;
        end else begin
          w_len_nxt    = w_frame_len;
          w_active_nxt = 1'b1;
        end
      end
      if (w_drop) begin
        w_wr_nxt     = r_commit_ptr;
        w_active_nxt = 1'b0;
        w_drop_inc   = w_drop_inc + 2'd1;
      end
    end
  end

  // Write-side pointers, frame tracking, length FIFO pointer and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_active     <= 1'b0;
      r_len        <= '0;
      r_lf_wr      <= '0;
      r_drop_cnt   <= '0;
    end else begin
      r_wr_ptr     <= w_wr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_active     <= w_active_nxt;
      r_len        <= w_len_nxt;
      if (w_push) r_lf_wr <= r_lf_wr + 1'b1;
      r_drop_cnt   <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
    end
  end

  // Data RAM write port and registered read port, plus length FIFO storage
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_base[AW-1:0]] <= din;
    r_ram_q <= r_mem[w_rd_addr];
    if (w_push) r_lf_mem[r_lf_wr[FW-1:0]] <= w_frame_len;
  end

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Read FSM next state, length pop and RAM read address (one-byte prefetch)
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rd_addr   = r_rd_ptr[AW-1:0];
    unique case (r_state)
      S_IDLE: begin
        if (!w_lf_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_rd_addr   = r_rd_ptr[AW-1:0] + 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        w_rd_addr = w_xfer ? r_rd_ptr[AW-1:0] + 2'd2 : r_rd_ptr[AW-1:0] + 1'b1;
        if (w_xfer && (r_rem == LW'(1))) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output register, remaining-byte count, read pointer and FIFO pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_lf_rd  <= '0;
      r_rem    <= '0;
      r_dout   <= '0;
      r_sop    <= 1'b0;
      r_eop    <= 1'b0;
      r_vld    <= 1'b0;
    end else begin
      if (w_pop) begin
        r_lf_rd <= r_lf_rd + 1'b1;
        r_rem   <= r_lf_mem[r_lf_rd[FW-1:0]];
      end
      case (r_state)
        S_LOAD: begin
          r_dout <= r_ram_q;
          r_vld  <= 1'b1;
          r_sop  <= 1'b1;
          r_eop  <= (r_rem == LW'(1));
        end
        S_SEND: begin
          if (w_xfer) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_rem    <= r_rem - 1'b1;
            if (r_rem == LW'(1)) begin
              r_vld <= 1'b0;
              r_sop <= 1'b0;
              r_eop <= 1'b0;
            end else begin
              r_dout <= r_ram_q;
              r_sop  <= 1'b0;
              r_eop  <= (r_rem == LW'(2));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dout     = r_dout;
  assign dout_sop = r_sop;
  assign dout_eop = r_eop;
  assign dout_vld = r_vld;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pkt_store_fwd.sv
// Bench for pkt_store_fwd: directed scenarios plus randomized traffic, all
// checked against a frame-level queue model of what must come out.
`timescale 1ns/1ps
module tb_pkt_store_fwd;

  localparam int DEPTH       = 256;
  localparam int MAX_PKT     = 128;
  localparam int LFIFO_DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = '0;
  logic        din_sop = 1'b0, din_eop = 1'b0, din_vld = 1'b0;
  logic [7:0]  dout;
  logic        dout_sop, dout_eop, dout_vld;
  logic        dout_rdy = 1'b1;
  logic [15:0] drop_cnt;

  pkt_store_fwd #(.DEPTH(DEPTH), .MAX_PKT(MAX_PKT), .LFIFO_DEPTH(LFIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_sop(din_sop), .din_eop(din_eop),
    .din_vld(din_vld), .dout(dout), .dout_sop(dout_sop), .dout_eop(dout_eop),
    .dout_vld(dout_vld), .dout_rdy(dout_rdy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  // Frame-level model: committed bytes awaiting output, plus the open frame
  logic [7:0] exp_b[$];
  int         exp_len[$];
  int         idx = 0;
  logic [7:0] cur[$];
  bit         m_active = 0;
  int         used = 0;
  int         m_drop = 0;
  int         n_xfer = 0, n_eop = 0;
  bit         prev_hold = 0;
  logic [9:0] prev_out;
  bit         xfer, ok;

  always @(negedge clk) begin
    if (rst) begin
      exp_b.delete(); exp_len.delete(); cur.delete();
      idx = 0; m_active = 0; used = 0; m_drop = 0; prev_hold = 0;
    end else begin
      check("drop_cnt", drop_cnt, (m_drop > 65535) ? 65535 : m_drop);
      if (prev_hold) begin
        check("hold_vld", dout_vld, 1);
        check("hold_data", {dout_sop, dout_eop, dout}, prev_out);
      end
      if (exp_len.size() == 0) check("idle_vld", dout_vld, 0);
      xfer = dout_vld && dout_rdy;
      if (xfer && exp_len.size() != 0) begin
        check("dout", dout, exp_b[0]);
        check("dout_sop", dout_sop, idx == 0);
        check("dout_eop", dout_eop, idx == exp_len[0] - 1);
        exp_b.delete(0);
        idx++; n_xfer++;
        if (dout_eop) n_eop++;
        if (idx == exp_len[0]) begin exp_len.delete(0); idx = 0; end
      end
      // Input byte seen at the coming edge; occupancy excludes this cycle's transfer
      if (din_vld && (din_sop || m_active)) begin
        if (din_sop) begin
          if (m_active) m_drop++;
          cur.delete();
          m_active = 1;
        end
        ok = !(cur.size() >= MAX_PKT || used + cur.size() >= DEPTH);
        if (ok) begin
          cur.push_back(din);
          if (din_eop) begin
            foreach (cur[i]) exp_b.push_back(cur[i]);
            exp_len.push_back(cur.size());
            used += cur.size();
            cur.delete();
            m_active = 0;
          end
        end else begin
          m_drop++;
          cur.delete();
          m_active = 0;
        end
      end
      if (xfer && used > 0) used--;
      prev_hold = dout_vld && !dout_rdy;
      prev_out  = {dout_sop, dout_eop, dout};
    end
  end

  bit rand_rdy = 0, tog_rdy = 0;
  int eop_cyc = 0;

  task automatic drive(input logic [7:0] d, input logic s, input logic e, input logic v);
    @(posedge clk); #1;
    din = d; din_sop = s; din_eop = e; din_vld = v;
    if (rand_rdy) dout_rdy = ($urandom_range(0, 3) != 0);
    else if (tog_rdy) dout_rdy = ~dout_rdy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int n, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      drive(8'($urandom), i == 0, with_eop && (i == n - 1), 1'b1);
      if (with_eop && i == n - 1) eop_cyc = cyc;
    end
  endtask

  task automatic send_ref10();
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = (i == 0) ? 8'h00 : (i == 1) ? 8'h0A : (i < 7) ? 8'hDD : 8'hEE;
      drive(b, i == 0, i == 9, 1'b1);
      if (i == 9) eop_cyc = cyc;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    idle(1);
    while (!(exp_len.size() == 0 && !dout_vld) && k < budget) begin
      idle(1);
      k++;
    end
    if (k >= budget) begin
      n_total++;
      $display("FAIL %s: output not drained, %0d frames still pending, required 0", name, exp_len.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1; din_vld = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  int base_x, base_e, k;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_sop", dout_sop, 0);
    check("rst_eop", dout_eop, 0);
    check("rst_vld", dout_vld, 0);
    check("rst_drop", drop_cnt, 0);

    // Single 10-byte frame: latency and content
    base_x = n_xfer; base_e = n_eop;
    send_ref10();
    k = 0;
    do begin idle(1); k++; end while (!dout_vld && k < 20);
    check("t1_latency", cyc - eop_cyc, 3);
    check("t1_first_byte", {dout_sop, dout}, {1'b1, 8'h00});
    wait_drain("t1_drain", 100);
    check("t1_xfers", n_xfer - base_x, 10);
    check("t1_frames", n_eop - base_e, 1);
    check("t1_drop", drop_cnt, 0);

    // 1-byte frame and exactly MAX_PKT frame
    base_x = n_xfer;
    send_frame(1, 1);
    send_frame(128, 1);
    wait_drain("t1b_drain", 400);
    check("t1b_xfers", n_xfer - base_x, 129);
    check("t1b_drop", drop_cnt, 0);

    // Backpressure: ready toggles every cycle
    base_x = n_xfer; base_e = n_eop;
    dout_rdy = 1'b1; tog_rdy = 1;
    send_ref10();
    wait_drain("t2_drain", 200);
    tog_rdy = 0; dout_rdy = 1'b1;
    check("t2_xfers", n_xfer - base_x, 10);
    check("t2_frames", n_eop - base_e, 1);

    // Oversize frame then a normal 64-byte frame
    do_reset();
    base_x = n_xfer; base_e = n_eop;
    send_frame(129, 1);
    idle(4);
    check("t3_drop", drop_cnt, 1);
    send_frame(64, 1);
    wait_drain("t3_drain", 300);
    check("t3_xfers", n_xfer - base_x, 64);
    check("t3_frames", n_eop - base_e, 1);

    // Truncated frame followed by a complete 68-byte frame
    do_reset();
    base_x = n_xfer; base_e = n_eop;
    send_frame(6, 0);
    send_frame(68, 1);
    wait_drain("t4_drain", 300);
    check("t4_drop", drop_cnt, 1);
    check("t4_xfers", n_xfer - base_x, 68);
    check("t4_frames", n_eop - base_e, 1);

    // Buffer full: third 100-byte frame does not fit while output is stalled
    do_reset();
    dout_rdy = 1'b0;
    base_x = n_xfer; base_e = n_eop;
    for (int f = 0; f < 3; f++) begin send_frame(100, 1); idle(2); end
    idle(4);
    check("t5_drop", drop_cnt, 1);
    check("t5_stalled_first", {dout_vld, dout_sop}, 2'b11);
    dout_rdy = 1'b1;
    wait_drain("t5_drain", 600);
    check("t5_xfers", n_xfer - base_x, 200);
    check("t5_frames", n_eop - base_e, 2);

    // Reset while byte 30 of a 64-byte frame is on the output
    do_reset();
    base_x = n_xfer; base_e = n_eop;
    send_frame(64, 1);
    k = 0;
    while (n_xfer - base_x < 29 && k < 200) begin idle(1); k++; end
    check("t6_reached_byte30", n_xfer - base_x, 29);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("t6_vld_after_rst", dout_vld, 0);
    check("t6_drop", drop_cnt, 0);
    check("t6_no_eop", n_eop - base_e, 0);
    base_x = n_xfer;
    send_frame(10, 1);
    wait_drain("t6_drain", 100);
    check("t6_xfers", n_xfer - base_x, 10);

    // Randomized traffic with random ready
    do_reset();
    rand_rdy = 1;
    for (int f = 0; f < 60; f++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      send_frame($urandom_range(129, 140), 1);
      else if (k == 1) send_frame($urandom_range(1, 30), 0);
      else             send_frame($urandom_range(20, 128), 1);
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        if ($urandom_range(0, 3) == 0) drive(8'($urandom), 1'b0, 1'b0, 1'b1);
        else idle(1);
      end
    end
    rand_rdy = 0; dout_rdy = 1'b1;
    wait_drain("rand_drain", 3000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
